// File: rtl/cv32e40p_div_pkg.sv
// Shared definitions for the divider issue stage.
//   - DIV_* opcode encodings (bit 0 selects signed operation)
//   - div_state_e : issue FSM states
//   - DIV_SHIFT_W : width of the shift amount handed to the divider
package cv32e40p_div_pkg;

  localparam logic [1:0] DIV_UDIV = 2'd0;
  localparam logic [1:0] DIV_DIV  = 2'd1;
  localparam logic [1:0] DIV_UREM = 2'd2;
  localparam logic [1:0] DIV_REM  = 2'd3;

  localparam int unsigned DIV_SHIFT_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } div_state_e;

endpackage

// File: rtl/cv32e40p_div_clb.sv
// Combinational leading-count unit for the divider shift amount.
//   op_i     : 32-bit divisor
//   signed_i : 1 = count leading sign-equal bits of op_i[30:0]
//   cnt_o    : unsigned -> min(lz(op_i) + 1, 32); signed -> run of op_i[31] in op_i[30:0]
module cv32e40p_div_clb
  import cv32e40p_div_pkg::*;
(
  input  logic [31:0]            op_i,
  input  logic                   signed_i,
  output logic [DIV_SHIFT_W-1:0] cnt_o
);

  // Balanced leading-zero counter: each level merges pairs of nodes, the upper
  // node wins if it holds a one, otherwise its full size is added to the lower count.
  function automatic logic [5:0] lzc32(input logic [31:0] v);
    logic [31:0] vld;
    logic [5:0]  cnt [32];
    for (int i = 0; i < 32; i++) begin
      vld[i] = v[31-i];
      cnt[i] = v[31-i] ? 6'd0 : 6'd1;
    end
    for (int lvl = 0; lvl < 5; lvl++) begin
      for (int j = 0; j < (16 >> lvl); j++) begin
        // In-place is safe: node j only reads nodes 2j and 2j+1, which are >= j.
        cnt[j] = vld[2*j] ? cnt[2*j] : 6'(1 << lvl) + cnt[2*j+1];
        vld[j] = vld[2*j] | vld[2*j+1];
      end
    end
    return cnt[0];
  endfunction

  logic [5:0] lz_unsigned;
  logic [5:0] lz_signed;

  always_comb begin
    lz_unsigned = lzc32(op_i);
    // Bits equal to the sign become zeros; the trailing one caps the count at 31.
    lz_signed   = lzc32({op_i[30:0] ^ {31{op_i[31]}}, 1'b1});
    if (signed_i) begin
      cnt_o = lz_signed;
    end else begin
      cnt_o = (lz_unsigned == 6'd32) ? 6'd32 : lz_unsigned + 6'd1;
    end
  end

endmodule

// File: rtl/cv32e40p_div_issue.sv
// Operand-preparation and issue stage in front of cv32e40p_alu_div.
//   ALU side     : InVld_SI/InRdy_SO, OpA_DI, OpB_DI, OpCode_SI
//   Divider side : DivOp*_DO/S O (held stable from issue to result handshake),
//                  DivInVld_SO one-cycle issue pulse, DivRes_DI/DivOutVld_SI/DivOutRdy_SO
//   Consumer     : Res_DO/OutVld_SO/OutRdy_SI, pass-through while BUSY only
module cv32e40p_div_issue
  import cv32e40p_div_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHIFT_W = 6
) (
  input  logic               Clk_CI,
  input  logic               Rst_RBI,
  input  logic               InVld_SI,
  output logic               InRdy_SO,
  input  logic [WIDTH-1:0]   OpA_DI,
  input  logic [WIDTH-1:0]   OpB_DI,
  input  logic [1:0]         OpCode_SI,
  output logic [WIDTH-1:0]   DivOpA_DO,
  output logic [WIDTH-1:0]   DivOpB_DO,
  output logic [SHIFT_W-1:0] DivOpBShift_DO,
  output logic               DivOpBIsZero_SO,
  output logic               DivOpBSign_SO,
  output logic [1:0]         DivOpCode_SO,
  output logic               DivInVld_SO,
  input  logic [WIDTH-1:0]   DivRes_DI,
  input  logic               DivOutVld_SI,
  output logic               DivOutRdy_SO,
  output logic [WIDTH-1:0]   Res_DO,
  output logic               OutVld_SO,
  input  logic               OutRdy_SI
);

  div_state_e         state_d, state_q;
  logic [WIDTH-1:0]   op_a_d, op_a_q;
  logic [WIDTH-1:0]   op_b_d, op_b_q;
  logic [SHIFT_W-1:0] shift_d, shift_q;
  logic               is_zero_d, is_zero_q;
  logic               sign_d, sign_q;
  logic [1:0]         opcode_d, opcode_q;
  logic               div_in_vld_d, div_in_vld_q;
  logic               in_rdy_d, in_rdy_q;

  logic               op_signed;
  logic [SHIFT_W-1:0] shift_calc;

  assign op_signed = OpCode_SI[0];

  cv32e40p_div_clb u_clb (
    .op_i     (OpB_DI),
    .signed_i (op_signed),
    .cnt_o    (shift_calc)
  );

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    shift_d      = shift_q;
    is_zero_d    = is_zero_q;
    sign_d       = sign_q;
    opcode_d     = opcode_q;
    div_in_vld_d = 1'b0;
    in_rdy_d     = in_rdy_q;
    unique case (state_q)
      IDLE: begin
        if (InVld_SI) begin
          op_a_d       = OpA_DI;
          op_b_d       = OpB_DI;
          shift_d      = shift_calc;
          is_zero_d    = (OpB_DI == '0);
          sign_d       = OpB_DI[WIDTH-1] & op_signed;
          opcode_d     = OpCode_SI;
          div_in_vld_d = 1'b1;
          in_rdy_d     = 1'b0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        state_d = BUSY;
      end
      BUSY: begin
        if (DivOutVld_SI && OutRdy_SI) begin
          in_rdy_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        in_rdy_d = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      shift_q      <= '0;
      is_zero_q    <= 1'b0;
      sign_q       <= 1'b0;
      opcode_q     <= 2'd0;
      div_in_vld_q <= 1'b0;
      in_rdy_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      shift_q      <= shift_d;
      is_zero_q    <= is_zero_d;
      sign_q       <= sign_d;
      opcode_q     <= opcode_d;
      div_in_vld_q <= div_in_vld_d;
      in_rdy_q     <= in_rdy_d;
    end
  end

  assign InRdy_SO        = in_rdy_q;
  assign DivInVld_SO     = div_in_vld_q;
  assign DivOpA_DO       = op_a_q;
  assign DivOpB_DO       = op_b_q;
  assign DivOpBShift_DO  = shift_q;
  assign DivOpBIsZero_SO = is_zero_q;
  assign DivOpBSign_SO   = sign_q;
  assign DivOpCode_SO    = opcode_q;

  // Result path is a gated pass-through so the divider's latency is not extended.
  always_comb begin
    DivOutRdy_SO = 1'b0;
    OutVld_SO    = 1'b0;
    Res_DO       = '0;
    if (state_q == BUSY) begin
      DivOutRdy_SO = OutRdy_SI;
      OutVld_SO    = DivOutVld_SI;
      Res_DO       = DivRes_DI;
    end
  end

endmodule
